// File: rtl/score_sequencer.sv
// Game-round controller: converts start/win/die levels into counter commands,
// tracks the high score and runs the timed end-of-round display.
module score_sequencer #(
  parameter int unsigned TICK_DIV   = 1024,
  parameter int unsigned HOLD_TICKS = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        win,
  input  logic        die,
  input  logic [11:0] score_bcd,
  output logic        score_inc,
  output logic        score_clr,
  output logic [11:0] disp_bcd,
  output logic        disp_blank,
  output logic        playing,
  output logic        new_record
);

  localparam int unsigned TW = $clog2(TICK_DIV);
  localparam int unsigned HW = $clog2(HOLD_TICKS + 1);

  typedef enum logic [1:0] {IDLE, PLAY, WRAP, OVER} state_t;

  state_t        state, state_nx;
  logic          start_q, win_q, die_q;
  logic          start_e, win_e, die_e;
  logic [TW-1:0] tick_cnt;
  logic          tick;
  logic          wrap_cnt, wrap_nx;
  logic [HW-1:0] hold_cnt, hold_nx;
  logic          blink_ph, blink_nx;
  logic [11:0]   high_bcd, high_nx;
  logic          rec_nx, inc_nx, clr_nx;

  assign start_e = start & ~start_q;
  assign win_e   = win & ~win_q;
  assign die_e   = die & ~die_q;
  assign tick    = (tick_cnt == TW'(TICK_DIV - 1));

  always_ff @(posedge clock) begin
    if (reset) begin
      start_q  <= 1'b0;
      win_q    <= 1'b0;
      die_q    <= 1'b0;
      tick_cnt <= '0;
    end else begin
      start_q  <= start;
      win_q    <= win;
      die_q    <= die;
      tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
    end
  end

  always_comb begin
    state_nx = state;
    wrap_nx  = wrap_cnt;
    hold_nx  = hold_cnt;
    blink_nx = blink_ph;
    high_nx  = high_bcd;
    rec_nx   = new_record;
    inc_nx   = 1'b0;
    clr_nx   = 1'b0;
    case (state)
      IDLE: begin
        if (start_e) begin
          state_nx = PLAY;
          clr_nx   = 1'b1;
          rec_nx   = 1'b0;
        end
      end
      PLAY: begin
        // die takes priority so a simultaneous win never reaches the counter
        if (die_e) begin
          state_nx = WRAP;
          wrap_nx  = 1'b0;
        end else if (win_e && score_bcd != 12'h999) begin
          inc_nx = 1'b1;
        end
      end
      WRAP: begin
        if (wrap_cnt) begin
          if (score_bcd > high_bcd) begin
            high_nx = score_bcd;
            rec_nx  = 1'b1;
          end
          state_nx = OVER;
          hold_nx  = '0;
          blink_nx = 1'b0;
        end else begin
          wrap_nx = 1'b1;
        end
      end
      OVER: begin
        if (tick) begin
          hold_nx  = hold_cnt + 1'b1;
          blink_nx = ~blink_ph;
          if (hold_nx == HW'(HOLD_TICKS)) state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      wrap_cnt   <= 1'b0;
      hold_cnt   <= '0;
      blink_ph   <= 1'b0;
      high_bcd   <= '0;
      new_record <= 1'b0;
      score_inc  <= 1'b0;
      score_clr  <= 1'b0;
      playing    <= 1'b0;
      disp_blank <= 1'b0;
    end else begin
      state      <= state_nx;
      wrap_cnt   <= wrap_nx;
      hold_cnt   <= hold_nx;
      blink_ph   <= blink_nx;
      high_bcd   <= high_nx;
      new_record <= rec_nx;
      score_inc  <= inc_nx;
      score_clr  <= clr_nx;
      playing    <= (state_nx == PLAY);
      disp_blank <= (state_nx == OVER) & rec_nx & blink_nx;
    end
  end

  always_comb begin
    disp_bcd = (state == IDLE) ? high_bcd : score_bcd;
  end

endmodule

// File: tb/tb_score_sequencer.sv
// Directed bench for score_sequencer with an attached BCD score counter model.
module tb_score_sequencer;

  logic        clock = 1'b0;
  logic        reset, start, win, die;
  logic [11:0] score_bcd = '0;
  logic        score_inc, score_clr, disp_blank, playing, new_record;
  logic [11:0] disp_bcd;

  logic        preload_en = 1'b0;
  logic [11:0] preload_val = '0;
  int          inc_cnt = 0;
  int          clr_cnt = 0;
  int          viol = 0;
  logic        prev_inc = 1'b0;
  int          checks = 0;
  int          errors = 0;
  int          over_len, blank_hi, inc0;

  score_sequencer #(.TICK_DIV(4), .HOLD_TICKS(3)) dut (
    .clock(clock), .reset(reset), .start(start), .win(win), .die(die),
    .score_bcd(score_bcd), .score_inc(score_inc), .score_clr(score_clr),
    .disp_bcd(disp_bcd), .disp_blank(disp_blank), .playing(playing),
    .new_record(new_record)
  );

  always #5 clock = ~clock;

  function automatic logic [11:0] bcd_inc(input logic [11:0] v);
    logic [11:0] r;
    r = v;
    if (r[3:0] != 4'd9) r[3:0] = r[3:0] + 4'd1;
    else begin
      r[3:0] = 4'd0;
      if (r[7:4] != 4'd9) r[7:4] = r[7:4] + 4'd1;
      else begin
        r[7:4]  = 4'd0;
        r[11:8] = (r[11:8] == 4'd9) ? 4'd0 : r[11:8] + 4'd1;
      end
    end
    return r;
  endfunction

  // Score counter model plus pulse counting/spacing monitor
  always @(posedge clock) begin
    if (reset) score_bcd <= '0;
    else if (preload_en) score_bcd <= preload_val;
    else if (score_clr) score_bcd <= '0;
    else if (score_inc) score_bcd <= bcd_inc(score_bcd);
    inc_cnt <= inc_cnt + (score_inc ? 1 : 0);
    clr_cnt <= clr_cnt + (score_clr ? 1 : 0);
    if ((score_inc && score_clr) || (score_inc && prev_inc)) viol <= viol + 1;
    prev_inc <= score_inc;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic pulse_start();
    start = 1'b1; cyc(1); start = 1'b0; cyc(1);
  endtask

  task automatic pulse_win();
    win = 1'b1; cyc(1); win = 1'b0; cyc(1);
  endtask

  // die edge, then two WRAP cycles; returns at the first OVER sample point
  task automatic end_round();
    die = 1'b1; cyc(1);
    check("wrap_playing", {31'd0, playing}, 32'd0);
    die = 1'b0; cyc(2);
  endtask

  // In OVER: fire an ignored start edge and move the counter to 777 so the
  // display mux shows whether the state is still OVER or back in IDLE.
  task automatic over_watch(output int len, output int hi);
    start = 1'b1; preload_en = 1'b1; preload_val = 12'h777;
    cyc(1);
    start = 1'b0; preload_en = 1'b0;
    len = 1; hi = 0;
    for (int i = 0; i < 20; i++) begin
      if (disp_bcd !== 12'h777) break;
      len++;
      if (disp_blank) hi++;
      cyc(1);
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; win = 1'b0; die = 1'b0;
    cyc(2);
    reset = 1'b0;
    cyc(1);
    check("rst_disp", {20'd0, disp_bcd}, 32'h000);
    check("rst_blank", {31'd0, disp_blank}, 32'd0);
    check("rst_pulses", {30'd0, score_inc, score_clr}, 32'd0);
    check("rst_playing", {31'd0, playing}, 32'd0);
    check("rst_record", {31'd0, new_record}, 32'd0);

    // Round 1: record round with 5 points
    pulse_start();
    check("r1_clr", clr_cnt, 1);
    check("r1_playing", {31'd0, playing}, 32'd1);
    check("r1_disp0", {20'd0, disp_bcd}, 32'h000);
    repeat (5) pulse_win();
    check("r1_inc", inc_cnt, 5);
    check("r1_disp5", {20'd0, disp_bcd}, 32'h005);
    pulse_start();
    check("play_start_ign", clr_cnt, 1);
    check("play_start_score", {20'd0, disp_bcd}, 32'h005);
    die = 1'b1; cyc(1);
    check("r1_wrap_rec", {31'd0, new_record}, 32'd0);
    die = 1'b0; start = 1'b1; cyc(1);
    start = 1'b0; cyc(1);
    check("r1_record", {31'd0, new_record}, 32'd1);
    check("r1_blank0", {31'd0, disp_blank}, 32'd0);
    over_watch(over_len, blank_hi);
    check("r1_over_len", {31'd0, over_len >= 9 && over_len <= 12}, 32'd1);
    check("r1_blank_hi", blank_hi, 4);
    check("r1_idle_disp", {20'd0, disp_bcd}, 32'h005);
    check("r1_idle_blank", {31'd0, disp_blank}, 32'd0);
    check("r1_idle_rec", {31'd0, new_record}, 32'd1);
    check("wrap_over_start_ign", clr_cnt, 1);

    // Round 2: 3 points, no record
    pulse_start();
    check("r2_rec_clr", {31'd0, new_record}, 32'd0);
    repeat (3) pulse_win();
    check("r2_inc", inc_cnt, 8);
    end_round();
    check("r2_record", {31'd0, new_record}, 32'd0);
    over_watch(over_len, blank_hi);
    check("r2_over_len", {31'd0, over_len >= 9 && over_len <= 12}, 32'd1);
    check("r2_blank_hi", blank_hi, 0);
    check("r2_idle_disp", {20'd0, disp_bcd}, 32'h005);

    // Round 3: win edge one cycle before die is committed (6 > 5)
    pulse_start();
    repeat (5) pulse_win();
    win = 1'b1; cyc(1);
    win = 1'b0; die = 1'b1; cyc(1);
    die = 1'b0; cyc(2);
    check("r3_record", {31'd0, new_record}, 32'd1);
    check("r3_score", {20'd0, disp_bcd}, 32'h006);
    over_watch(over_len, blank_hi);
    check("r3_idle_disp", {20'd0, disp_bcd}, 32'h006);

    // Round 4: simultaneous win/die gives no increment
    pulse_start();
    pulse_win();
    inc0 = inc_cnt;
    win = 1'b1; die = 1'b1; cyc(1);
    check("r4_wrap_playing", {31'd0, playing}, 32'd0);
    win = 1'b0; die = 1'b0; cyc(2);
    check("r4_no_inc", inc_cnt, inc0);
    check("r4_score", {20'd0, disp_bcd}, 32'h001);
    check("r4_record", {31'd0, new_record}, 32'd0);
    over_watch(over_len, blank_hi);
    check("r4_idle_disp", {20'd0, disp_bcd}, 32'h006);

    // Round 5: saturation at 999, then reset during OVER
    pulse_start();
    preload_en = 1'b1; preload_val = 12'h999; cyc(1);
    preload_en = 1'b0;
    inc0 = inc_cnt;
    pulse_win();
    check("sat_no_inc", inc_cnt, inc0);
    check("sat_score", {20'd0, disp_bcd}, 32'h999);
    end_round();
    check("r5_record", {31'd0, new_record}, 32'd1);
    for (int i = 0; i < 6; i++) begin
      if (disp_blank) break;
      cyc(1);
    end
    check("r5_blank_on", {31'd0, disp_blank}, 32'd1);
    reset = 1'b1; cyc(1);
    check("mid_rst_disp", {20'd0, disp_bcd}, 32'h000);
    check("mid_rst_blank", {31'd0, disp_blank}, 32'd0);
    check("mid_rst_rec", {31'd0, new_record}, 32'd0);
    check("mid_rst_pulses", {30'd0, score_inc, score_clr}, 32'd0);
    reset = 1'b0; cyc(2);
    check("clr_total", clr_cnt, 5);
    check("pulse_spacing", viol, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
